counter_up_mod: RTL and testbench

Synchronous modulo-N up counter with clock-enable prescaler, parallel load, terminal-count pulse and sticky overflow flag. It is the up-counting counterpart of the team's 4-bit down counter. It drives event sequencing and timebase generation in the same designs, so the two counters can be paired as a matched up/down timebase. At default parameters it behaves as a plain free-running 4-bit up counter.

---
 rtl/counter_up_mod.sv | 85 ++++++++
 tb/tb_counter_up_mod.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_up_mod.sv
// counter_up_mod: modulo-MODULO up counter with an enable prescaler, a
// clamped parallel load, a one-clock terminal-count pulse and a sticky
// overflow flag. Paired with the 4-bit down counter as an up/down timebase.
module counter_up_mod #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             overflow
);

  // Prescaler needs at least one bit even when PRESCALE==1 (it then stays 0).
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULO - 1);
  localparam logic [PW-1:0]    PRE_MAX   = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_reg, count_next;
  logic [PW-1:0]    pre_reg, pre_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             wrap;

  // Next-state decode: load beats step, step beats hold; wrap beats clear_ovf.
  always_comb begin
    count_next = count_reg;
    pre_next   = pre_reg;
    tc_next    = 1'b0;
    wrap       = 1'b0;
    if (load) begin
      // Out-of-range load values saturate so no count >= MODULO is reachable.
      count_next = (load_value > COUNT_MAX) ? COUNT_MAX : load_value;
      pre_next   = '0;
    end else if (enable) begin
      if (pre_reg == PRE_MAX) begin
        pre_next = '0;
        if (count_reg == COUNT_MAX) begin
          count_next = '0;
          wrap       = 1'b1;
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
      end else begin
        pre_next = pre_reg + PW'(1);
      end
    end
    tc_next = wrap;
    if (wrap) begin
      ovf_next = 1'b1;
    end else if (clear_ovf) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf_reg;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= '0;
      pre_reg   <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      pre_reg   <= pre_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count    = count_reg;
  assign tc       = tc_reg;
  assign overflow = ovf_reg;
  assign at_max   = (count_reg == COUNT_MAX);

endmodule

// File: tb/tb_counter_up_mod.sv
// Bench for counter_up_mod: three instances (defaults, MODULO=10, PRESCALE=3)
// checked every cycle against a behavioural model, plus literal expectations.
module tb_counter_up_mod;

  logic       clock = 1'b0;
  logic       rst [3];
  logic       en  [3];
  logic       ld  [3];
  logic       cov [3];
  logic [3:0] lv  [3];
  logic [3:0] d_cnt [3];
  logic       d_tc  [3];
  logic       d_max [3];
  logic       d_ovf [3];

  int checks = 0;
  int failures = 0;

  // Behavioural model state, one slot per instance.
  int m_cnt [3];
  int m_pre [3];
  bit m_tc  [3];
  bit m_ovf [3];
  bit m_valid [3];

  always #5 clock = ~clock;

  counter_up_mod u0 (
    .clock(clock), .reset(rst[0]), .enable(en[0]), .load(ld[0]),
    .load_value(lv[0]), .clear_ovf(cov[0]),
    .count(d_cnt[0]), .tc(d_tc[0]), .at_max(d_max[0]), .overflow(d_ovf[0]));

  counter_up_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u1 (
    .clock(clock), .reset(rst[1]), .enable(en[1]), .load(ld[1]),
    .load_value(lv[1]), .clear_ovf(cov[1]),
    .count(d_cnt[1]), .tc(d_tc[1]), .at_max(d_max[1]), .overflow(d_ovf[1]));

  counter_up_mod #(.WIDTH(4), .MODULO(16), .PRESCALE(3)) u2 (
    .clock(clock), .reset(rst[2]), .enable(en[2]), .load(ld[2]),
    .load_value(lv[2]), .clear_ovf(cov[2]),
    .count(d_cnt[2]), .tc(d_tc[2]), .at_max(d_max[2]), .overflow(d_ovf[2]));

  function automatic int mod_of(int i);
    return (i == 1) ? 10 : 16;
  endfunction

  function automatic int pre_of(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: count enabled edges; every PRESCALE-th one advances count mod MODULO.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      bit wrapped;
      wrapped = 1'b0;
      if (!rst[i]) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
        m_valid[i] = 1'b1;
      end else begin
        if (ld[i]) begin
          m_cnt[i] = (int'(lv[i]) > mod_of(i) - 1) ? mod_of(i) - 1 : int'(lv[i]);
          m_pre[i] = 0;
        end else if (en[i]) begin
          m_pre[i] = m_pre[i] + 1;
          if (m_pre[i] == pre_of(i)) begin
            m_pre[i] = 0;
            wrapped  = (m_cnt[i] + 1 == mod_of(i));
            m_cnt[i] = (m_cnt[i] + 1) % mod_of(i);
          end
        end
        m_tc[i] = wrapped;
        if (wrapped) m_ovf[i] = 1'b1;
        else if (cov[i]) m_ovf[i] = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i]) begin
        chk($sformatf("u%0d.count", i), 32'(d_cnt[i]), 32'(m_cnt[i]));
        chk($sformatf("u%0d.tc", i), 32'(d_tc[i]), 32'(m_tc[i]));
        chk($sformatf("u%0d.overflow", i), 32'(d_ovf[i]), 32'(m_ovf[i]));
        chk($sformatf("u%0d.at_max", i), 32'(d_max[i]), 32'(m_cnt[i] == mod_of(i) - 1));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; en[i] = 1'b1; ld[i] = 1'b0; cov[i] = 1'b0; lv[i] = 4'd0;
    end
    tick(2);
    for (int i = 0; i < 3; i++) begin
      chk("reset_count", 32'(d_cnt[i]), 0);
      chk("reset_tc", 32'(d_tc[i]), 0);
      chk("reset_ovf", 32'(d_ovf[i]), 0);
      chk("reset_at_max", 32'(d_max[i]), 0);
    end

    // Defaults: free-running ramp, wrap, flags.
    rst[0] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      chk("ramp", 32'(d_cnt[0]), 32'(k));
    end
    chk("at_max_15", 32'(d_max[0]), 1);
    tick(1);
    chk("wrap_count", 32'(d_cnt[0]), 0);
    chk("wrap_tc", 32'(d_tc[0]), 1);
    chk("wrap_ovf", 32'(d_ovf[0]), 1);
    tick(1);
    chk("tc_fall", 32'(d_tc[0]), 0);
    chk("ovf_sticky", 32'(d_ovf[0]), 1);
    en[0] = 1'b0; cov[0] = 1'b1;
    tick(1);
    cov[0] = 1'b0;
    chk("ovf_clear", 32'(d_ovf[0]), 0);
    chk("hold_count", 32'(d_cnt[0]), 1);
    ld[0] = 1'b1; lv[0] = 4'd15;
    tick(1);
    chk("load_15", 32'(d_cnt[0]), 15);
    lv[0] = 4'd5; en[0] = 1'b1;
    tick(1);
    chk("load_over_enable", 32'(d_cnt[0]), 5);
    chk("load_no_tc", 32'(d_tc[0]), 0);
    lv[0] = 4'd15; en[0] = 1'b0;
    tick(1);
    ld[0] = 1'b0; en[0] = 1'b1; cov[0] = 1'b1;
    tick(1);
    cov[0] = 1'b0; en[0] = 1'b0;
    chk("wrap_vs_clear_ovf", 32'(d_ovf[0]), 1);
    chk("wrap_vs_clear_tc", 32'(d_tc[0]), 1);

    // MODULO=10: wrap at 9, clamp on load.
    rst[1] = 1'b1;
    tick(9);
    chk("m10_count9", 32'(d_cnt[1]), 9);
    chk("m10_at_max", 32'(d_max[1]), 1);
    tick(1);
    chk("m10_wrap", 32'(d_cnt[1]), 0);
    chk("m10_tc", 32'(d_tc[1]), 1);
    en[1] = 1'b0; ld[1] = 1'b1; lv[1] = 4'd12;
    tick(1);
    chk("m10_clamp", 32'(d_cnt[1]), 9);
    chk("m10_clamp_at_max", 32'(d_max[1]), 1);
    lv[1] = 4'd3;
    tick(1);
    ld[1] = 1'b0;
    chk("m10_load3", 32'(d_cnt[1]), 3);

    // PRESCALE=3: step every third enabled edge, gaps pause.
    rst[2] = 1'b1;
    tick(2);
    chk("p3_edge2", 32'(d_cnt[2]), 0);
    tick(1);
    chk("p3_edge3", 32'(d_cnt[2]), 1);
    tick(2);
    chk("p3_edge5", 32'(d_cnt[2]), 1);
    en[2] = 1'b0;
    tick(4);
    chk("p3_gap", 32'(d_cnt[2]), 1);
    en[2] = 1'b1;
    tick(1);
    chk("p3_resume", 32'(d_cnt[2]), 2);

    // Reset mid-prescale at count=7, prescaler=2.
    en[2] = 1'b0; ld[2] = 1'b1; lv[2] = 4'd7;
    tick(1);
    ld[2] = 1'b0; en[2] = 1'b1;
    tick(2);
    chk("p3_count7", 32'(d_cnt[2]), 7);
    rst[2] = 1'b0;
    tick(1);
    chk("mid_reset_count", 32'(d_cnt[2]), 0);
    chk("mid_reset_ovf", 32'(d_ovf[2]), 0);
    rst[2] = 1'b1;
    tick(2);
    chk("post_reset_2", 32'(d_cnt[2]), 0);
    tick(1);
    chk("post_reset_3", 32'(d_cnt[2]), 1);

    tick(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
